// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider, one quotient bit per clock.
// Supports unsigned and (optionally) two's-complement operands, with a
// divide-by-zero flag and a signed-overflow flag (most-negative / -1).
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous, active-low reset
//   start        request, sampled only while idle
//   signed_mode  1 = two's-complement operands (honoured only when SIGNED_EN=1)
//   dividend     dividend, latched with start
//   divisor      divisor, latched with start
//   busy         high while an operation is in progress (RUN and FIN)
//   done         one-cycle pulse, results valid while high
//   quotient     result quotient, held until the next result
//   remainder    result remainder, held until the next result
//   div_by_zero  last result was a division by zero
//   overflow     last result was signed most-negative / -1
module seq_divider #(
   parameter int unsigned WIDTH     = 8,
   parameter bit          SIGNED_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             signed_mode,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero,
   output logic             overflow
);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StRun  = 2'd1;
   localparam logic [1:0] StFin  = 2'd2;

   localparam int unsigned CntW = $clog2(WIDTH + 1);
   localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH - 1){1'b0}}};

   logic [1:0]       state_q;
   logic [CntW-1:0]  cnt_q;
   logic [WIDTH-1:0] rem_q;    // partial remainder
   logic [WIDTH-1:0] dq_q;     // dividend magnitude, shifted out while quotient bits shift in
   logic [WIDTH-1:0] dvs_q;    // divisor magnitude
   logic             q_neg_q;
   logic             r_neg_q;
   logic             ovf_q;

   logic             sgn;
   logic             a_neg;
   logic             b_neg;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic             is_ovf;
   logic [WIDTH:0]   trial;
   logic             step_neg;
   logic [WIDTH-1:0] rem_nxt;
   logic [WIDTH-1:0] dq_nxt;
   logic [WIDTH-1:0] q_fix;
   logic [WIDTH-1:0] r_fix;

   always_comb begin
      sgn    = SIGNED_EN && signed_mode;
      a_neg  = sgn && dividend[WIDTH-1];
      b_neg  = sgn && divisor[WIDTH-1];
      a_mag  = a_neg ? (~dividend + 1'b1) : dividend;
      b_mag  = b_neg ? (~divisor + 1'b1) : divisor;
      is_ovf = sgn && (dividend == MinNeg) && (divisor == '1);

      // The partial remainder is always below the divisor, so the shifted
      // value minus the divisor fits a (WIDTH+1)-bit two's-complement result.
      trial    = {rem_q, dq_q[WIDTH-1]} - {1'b0, dvs_q};
      step_neg = trial[WIDTH];
      rem_nxt  = step_neg ? {rem_q[WIDTH-2:0], dq_q[WIDTH-1]} : trial[WIDTH-1:0];
      dq_nxt   = {dq_q[WIDTH-2:0], ~step_neg};

      q_fix = q_neg_q ? (~dq_nxt + 1'b1) : dq_nxt;
      r_fix = r_neg_q ? (~rem_nxt + 1'b1) : rem_nxt;
   end

   assign busy = (state_q != StIdle);

   // Results are registered on the edge that enters FIN so they are already
   // valid while done is high.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         rem_q       <= '0;
         dq_q        <= '0;
         dvs_q       <= '0;
         q_neg_q     <= 1'b0;
         r_neg_q     <= 1'b0;
         ovf_q       <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_q)
            StIdle: begin
               if (start) begin
                  q_neg_q <= a_neg ^ b_neg;
                  r_neg_q <= a_neg;
                  dq_q    <= a_mag;
                  dvs_q   <= b_mag;
                  rem_q   <= '0;
                  ovf_q   <= is_ovf;
                  if (divisor == '0) begin
                     quotient    <= '1;
                     remainder   <= dividend;
                     div_by_zero <= 1'b1;
                     overflow    <= 1'b0;
                     done        <= 1'b1;
                     state_q     <= StFin;
                  end else begin
                     cnt_q   <= CntW'(WIDTH);
                     state_q <= StRun;
                  end
               end
            end
            StRun: begin
               rem_q <= rem_nxt;
               dq_q  <= dq_nxt;
               cnt_q <= cnt_q - 1'b1;
               if (cnt_q == CntW'(1)) begin
                  quotient    <= q_fix;
                  remainder   <= r_fix;
                  div_by_zero <= 1'b0;
                  overflow    <= ovf_q;
                  done        <= 1'b1;
                  state_q     <= StFin;
               end
            end
            StFin:   state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: WIDTH=8 instance checked through a scoreboard
// against an arithmetic reference model, plus a WIDTH=16 latency check.
module tb_seq_divider;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic         signed_mode;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         busy;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;
   logic         overflow;

   logic         start16;
   logic [15:0]  dvd16;
   logic [15:0]  dvs16;
   logic         busy16;
   logic         done16;
   logic [15:0]  q16;
   logic [15:0]  r16;
   logic         dz16;
   logic         ovf16;

   always #5 clk = ~clk;

   seq_divider #(.WIDTH(W), .SIGNED_EN(1'b1)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
      .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
      .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero),
      .overflow(overflow)
   );

   seq_divider #(.WIDTH(16), .SIGNED_EN(1'b1)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .start(start16), .signed_mode(1'b0),
      .dividend(dvd16), .divisor(dvs16), .busy(busy16), .done(done16),
      .quotient(q16), .remainder(r16), .div_by_zero(dz16), .overflow(ovf16)
   );

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dz;
      logic         ovf;
      int           cyc;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: plain integer division, truncating toward zero.
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm);
      exp_t e;
      int   sa;
      int   sb;
      e.dz  = 1'b0;
      e.ovf = 1'b0;
      e.cyc = 0;
      if (b == 0) begin
         e.q  = '1;
         e.r  = a;
         e.dz = 1'b1;
      end else if (!sm) begin
         e.q = a / b;
         e.r = a % b;
      end else begin
         sa = $signed(a);
         sb = $signed(b);
         if (sa == -(1 << (W - 1)) && sb == -1) begin
            e.q   = W'(sa);
            e.r   = '0;
            e.ovf = 1'b1;
         end else begin
            e.q = W'(sa / sb);
            e.r = W'(sa % sb);
         end
      end
      return e;
   endfunction

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      exp_t e;
      if (done) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_done", done, 1'b0);
         end else begin
            e = sb_q.pop_front();
            chk("quotient", quotient, e.q);
            chk("remainder", remainder, e.r);
            chk("div_by_zero", div_by_zero, e.dz);
            chk("overflow", overflow, e.ovf);
            chk("done_cycle", cyc, e.cyc);
            chk("busy_at_done", busy, 1'b1);
         end
      end
   end

   task automatic wait_idle();
      int guard = 0;
      while (busy && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (busy) chk("idle_wait", busy, 1'b0);
   endtask

   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm,
                        input bit push);
      exp_t e;
      wait_idle();
      dividend    = a;
      divisor     = b;
      signed_mode = sm;
      start       = 1'b1;
      if (push) begin
         e     = model(a, b, sm);
         e.cyc = cyc + 1 + ((b == 0) ? 0 : W);
         sb_q.push_back(e);
      end
      @(negedge clk);
      start       = 1'b0;
      dividend    = W'($urandom);
      divisor     = W'($urandom);
      signed_mode = 1'($urandom);
   endtask

   initial begin
      int   n;
      int   n0;
      exp_t e;
      rst_n       = 1'b0;
      start       = 1'b0;
      signed_mode = 1'b0;
      dividend    = '0;
      divisor     = '0;
      start16     = 1'b0;
      dvd16       = '0;
      dvs16       = '0;
      repeat (3) @(negedge clk);
      chk("rst_quotient", quotient, 0);
      chk("rst_remainder", remainder, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_dz", div_by_zero, 0);
      chk("rst_ovf", overflow, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // 100/7 and busy length
      issue(8'd100, 8'd7, 1'b0, 1'b1);
      n = 0;
      while (busy && n < 50) begin
         n++;
         @(negedge clk);
      end
      chk("busy_cycles", n, W + 1);

      issue(8'd255, 8'd1, 1'b0, 1'b1);
      issue(8'd5, 8'd9, 1'b0, 1'b1);
      issue(8'h5A, 8'h00, 1'b0, 1'b1);
      issue(8'd20, 8'd3, 1'b0, 1'b1);
      issue(8'hF9, 8'd2, 1'b1, 1'b1);
      issue(8'd7, 8'hFE, 1'b1, 1'b1);
      issue(8'h80, 8'hFF, 1'b1, 1'b1);
      issue(8'h80, 8'hFF, 1'b0, 1'b1);
      issue(8'hF9, 8'h00, 1'b1, 1'b1);

      // start pulsed at edge 3 of an operation is ignored
      issue(8'd200, 8'd13, 1'b0, 1'b1);
      repeat (2) @(negedge clk);
      dividend = 8'd1;
      divisor  = 8'd1;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;

      // start held: back-to-back results every W+2 cycles
      wait_idle();
      dividend    = 8'd77;
      divisor     = 8'd5;
      signed_mode = 1'b0;
      start       = 1'b1;
      n0          = cyc;
      for (int i = 0; i < 3; i++) begin
         e     = model(8'd77, 8'd5, 1'b0);
         e.cyc = n0 + 1 + W + i * (W + 2);
         sb_q.push_back(e);
      end
      repeat (2 * (W + 2) + 1) @(negedge clk);
      start = 1'b0;

      // reset at edge 4 aborts the operation
      issue(8'd100, 8'd7, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("midrst_quotient", quotient, 0);
      chk("midrst_remainder", remainder, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      n = 0;
      repeat (12) begin
         @(negedge clk);
         if (done) n++;
      end
      chk("no_done_after_reset", n, 0);
      issue(8'd100, 8'd7, 1'b0, 1'b1);

      // random sweeps
      for (int i = 0; i < 1000; i++) issue(W'($urandom), W'($urandom), 1'b0, 1'b1);
      for (int i = 0; i < 300; i++) begin
         if (i % 50 == 0) issue(8'h80, 8'hFF, 1'b1, 1'b1);
         else issue(W'($urandom), W'($urandom_range(0, 15) == 0 ? 0 : $urandom), 1'b1, 1'b1);
      end

      // WIDTH=16: 100/7 done after edge 16
      wait_idle();
      dvd16   = 16'd100;
      dvs16   = 16'd7;
      start16 = 1'b1;
      n0      = cyc;
      @(negedge clk);
      start16 = 1'b0;
      dvd16   = 16'hFFFF;
      n = 0;
      while (!done16 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("w16_done_cycle", cyc, n0 + 1 + 16);
      chk("w16_quotient", q16, 16'd14);
      chk("w16_remainder", r16, 16'd2);
      chk("w16_flags", {dz16, ovf16}, 2'b00);

      n = 0;
      while (sb_q.size() > 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("scoreboard_drain", sb_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
